clique_collector: RTL and testbench
===================================

# clique_collector

Synthesizable receiver for the clique result stream emitted by `justwu_top` (`o_clq_valid` / `o_clq_size` / `o_clq_v`). It tracks the running maximum clique size, counts the cliques of that size, and buffers their vertex lists in an on-chip RAM. A host or debug path reads results back through a random-access port. It sits directly downstream of the clique search core and replaces bench-side result collection in on-board runs.

## Interface
- `VW`, 10: vertex index width; equals `` `MATRIX_WIDTHV ``.
- `SW`, 5: clique size width; equals `` `MAX_CLIQUESIZEBITS ``.
- `DEPTH`, 128: vertex storage entries; power of two.
- `AW`, `$clog2(DEPTH)`: storage address width.

Ports:
- `i_clk`  in  1  clock. One clock domain; reset is asynchronous and active-low.
- `i_reset_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  single-cycle pulse. Clears all results and loads `i_init_maxsize`.
- `i_init_maxsize`  in  SW  initial size threshold, sampled on `i_start`.
- `i_clq_valid`  in  1  stream beat valid.
- `i_clq_size`  in  SW  size of the clique in the current burst; constant within a burst.
- `i_clq_v`  in  VW  vertex index of the current beat.
- `o_maxsize`  out  SW  current maximum clique size.
- `o_n_cliques`  out  32  number of cliques stored or counted at `o_maxsize`.
- `o_n_vertices`  out  AW+1  number of valid storage entries.
- `o_dropped`  out  16  count of bursts discarded for `size < o_maxsize`; saturates.
- `o_overflow`  out  1  sticky: at least one vertex was lost because storage was full.
- `o_len_err`  out  1  sticky: an accepted burst's beat count differed from its size.
- `o_busy`  out  1  high while the FSM is not in `S_IDLE`.
- `i_rd_addr`  in  AW  readout address.
- `o_rd_data`  out  VW  registered readout data.

## Operation
- **Burst definition:** a burst is a maximal run of consecutive cycles with `i_clq_valid`=1, one vertex per beat. Bursts must be separated by at least one idle cycle. Back-to-back runs with no idle cycle are treated as a single burst.
- **FSM states:** `S_IDLE`, `S_ACTIVE`, `S_DROP`.
- **`S_IDLE`, valid beat:**
  - If `size > o_maxsize`: set `o_maxsize`=size, `o_n_cliques`=1, write the vertex to address 0, set `o_n_vertices`=1, go to `S_ACTIVE`.
  - If `size == o_maxsize`: increment `o_n_cliques`, write the vertex at `o_n_vertices`, increment `o_n_vertices`, go to `S_ACTIVE`.
  - If `size < o_maxsize`: increment `o_dropped` (saturating), go to `S_DROP`. No other state changes.
- **`S_ACTIVE`, valid beat:** write the vertex at `o_n_vertices`, increment `o_n_vertices`.
- **`S_ACTIVE`, valid low:** return to `S_IDLE`. Compare the internal beat count with the latched burst size; if they differ, set `o_len_err`.
- **`S_DROP`:** ignore beats. Return to `S_IDLE` when valid is low.
- **Storage full:** when `o_n_vertices == DEPTH`, further writes are suppressed and `o_overflow` is set. Counters other than `o_n_vertices` keep updating. A restart (`size > o_maxsize`) makes room again but does not clear `o_overflow`.
- **Beat counter:** SW+1 bits wide, saturating.
- **`i_start`:**
  - Has priority over everything else.
  - Clears `o_n_cliques`, `o_n_vertices`, `o_dropped`, `o_overflow` and `o_len_err`, and loads `o_maxsize`=`i_init_maxsize`.
  - Any beat present in the same cycle is discarded.
  - If `i_clq_valid`=1 in the start cycle, go to `S_DROP`; otherwise go to `S_IDLE`.
- **Storage contents:** RAM contents are not reset. Reads at addresses ≥ `o_n_vertices` return stale data.

## Timing
- **Reset values:** all outputs 0, including `o_rd_data` and `o_busy`; FSM in `S_IDLE`. Reset asserted mid-burst: the remainder of that burst is seen from `S_IDLE` after deassertion and is processed as a new burst.
- **Counter/status latency:** counters and flags update on the edge that samples the beat and are visible the following cycle. `o_len_err` is visible one cycle after the first idle cycle.
- **Readout latency:** `o_rd_data` reflects `i_rd_addr` one cycle later.
- **Read/write collision:** a read and a write to the same address in the same cycle returns the old data (read-before-write).
- **Throughput:** one beat per cycle with no backpressure. The block never stalls the stream.

## Test plan
1. Start with init 3; send a size-4 burst 1,5,7,9; idle. Required: `o_maxsize`=4, `o_n_cliques`=1, `o_n_vertices`=4; reading addresses 0..3 returns 1,5,7,9 with 1-cycle latency.
2. Continue with a size-4 burst 2,3,4,6. Required: `o_n_cliques`=2, `o_n_vertices`=8, address 4 returns 2.
3. Continue with a size-5 burst 0,1,2,3,8. Required: `o_maxsize`=5, `o_n_cliques`=1, `o_n_vertices`=5, address 0 returns 0.
4. Continue with a size-3 burst. Required: `o_dropped`=1; all other outputs unchanged. Then send a size-5 burst of only 4 beats. Required: `o_len_err`=1, `o_n_cliques`=2, `o_n_vertices`=9.
5. With DEPTH=8: start with init 0; send three size-3 bursts. Required: `o_n_cliques`=3, `o_n_vertices`=8, `o_overflow`=1, and the 9th vertex is not written.
6. Assert `i_start` on the 2nd beat of a size-4 burst with init 2. Required: the remaining beats are ignored, `o_n_cliques`=0, `o_busy` stays high until valid drops. Separately, assert `i_reset_n` low mid-burst. Required: all outputs read 0 immediately (asynchronous reset).

Source files
------------

// File: rtl/clique_collector_if.sv
// ============================================================================
//  Module   : clique_collector_if
//  Purpose  : Clique result stream (valid / size / vertex) from the search core.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface clique_collector_if #(
    parameter int VW = 10,
    parameter int SW = 5
);
    logic          clq_valid;
    logic [SW-1:0] clq_size;
    logic [VW-1:0] clq_v;

    modport master (output clq_valid, clq_size, clq_v);
    modport slave  (input  clq_valid, clq_size, clq_v);
endinterface

`default_nettype wire

// File: rtl/clique_collector.sv
// ============================================================================
//  Module   : clique_collector
//  Purpose  : Tracks the maximum clique size, counts cliques of that size and
//             buffers their vertex lists for random-access readout.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module clique_collector #(
    parameter int VW    = 10,
    parameter int SW    = 5,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [SW-1:0]     i_init_maxsize,
    clique_collector_if.slave clq,
    output logic [SW-1:0]     o_maxsize,
    output logic [31:0]       o_n_cliques,
    output logic [AW:0]       o_n_vertices,
    output logic [15:0]       o_dropped,
    output logic              o_overflow,
    output logic              o_len_err,
    output logic              o_busy,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [VW-1:0]     o_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DROP   = 2'd2
    } state_t;

    localparam logic [AW:0] c_depth = DEPTH[AW:0];

    state_t          r_state;
    state_t          w_state_next;

    logic [SW-1:0]   r_maxsize;
    logic [31:0]     r_n_cliques;
    logic [AW:0]     r_n_vertices;
    logic [15:0]     r_dropped;
    logic            r_overflow;
    logic            r_len_err;
    logic [SW-1:0]   r_burst_size;
    logic [SW:0]     r_beat_cnt;
    logic [VW-1:0]   r_rd_data;
    logic [VW-1:0]   r_mem [DEPTH];

    logic            w_valid;
    logic            w_full;
    logic            w_restart;
    logic            w_join;
    logic            w_drop;
    logic            w_extend;
    logic            w_close;
    logic            w_append;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;

    assign w_valid = clq.clq_valid;
    assign w_full  = (r_n_vertices == c_depth);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_join       = 1'b0;
        w_drop       = 1'b0;
        w_extend     = 1'b0;
        w_close      = 1'b0;
        if (i_start) begin
            // A beat coinciding with start is discarded along with its burst
            w_state_next = w_valid ? S_DROP : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        if (clq.clq_size > r_maxsize) begin
                            w_restart    = 1'b1;
                            w_state_next = S_ACTIVE;
                        end else if (clq.clq_size == r_maxsize) begin
                            w_join       = 1'b1;
                            w_state_next = S_ACTIVE;
                        end else begin
                            w_drop       = 1'b1;
                            w_state_next = S_DROP;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_valid) begin
                        w_extend = 1'b1;
                    end else begin
                        w_close      = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                S_DROP: begin
                    if (!w_valid) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // A restart always lands at address 0, so it can never hit the full condition
    assign w_append  = w_join | w_extend;
    assign w_wr_en   = i_reset_n & (w_restart | (w_append & ~w_full));
    assign w_wr_addr = w_restart ? '0 : r_n_vertices[AW-1:0];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_maxsize    <= '0;
            r_n_cliques  <= '0;
            r_n_vertices <= '0;
            r_dropped    <= '0;
            r_overflow   <= 1'b0;
            r_len_err    <= 1'b0;
            r_burst_size <= '0;
            r_beat_cnt   <= '0;
        end else if (i_start) begin
            r_maxsize    <= i_init_maxsize;
            r_n_cliques  <= '0;
            r_n_vertices <= '0;
            r_dropped    <= '0;
            r_overflow   <= 1'b0;
            r_len_err    <= 1'b0;
            r_burst_size <= '0;
            r_beat_cnt   <= '0;
        end else begin
            if (w_restart) begin
                r_maxsize    <= clq.clq_size;
                r_n_cliques  <= 32'd1;
                r_n_vertices <= {{AW{1'b0}}, 1'b1};
                r_burst_size <= clq.clq_size;
                r_beat_cnt   <= {{SW{1'b0}}, 1'b1};
            end
            if (w_join) begin
                r_n_cliques  <= r_n_cliques + 32'd1;
                r_burst_size <= clq.clq_size;
                r_beat_cnt   <= {{SW{1'b0}}, 1'b1};
            end
            if (w_append) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_n_vertices <= r_n_vertices + 1'b1;
                end
            end
            if (w_extend && (r_beat_cnt != '1)) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
            if (w_drop && (r_dropped != 16'hFFFF)) begin
                r_dropped <= r_dropped + 16'd1;
            end
            if (w_close && (r_beat_cnt != {1'b0, r_burst_size})) begin
                r_len_err <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset so it maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= clq.clq_v;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_maxsize    = r_maxsize;
    assign o_n_cliques  = r_n_cliques;
    assign o_n_vertices = r_n_vertices;
    assign o_dropped    = r_dropped;
    assign o_overflow   = r_overflow;
    assign o_len_err    = r_len_err;
    assign o_busy       = (r_state != S_IDLE);
    assign o_rd_data    = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_clique_collector.sv
// ============================================================================
//  Module   : tb_clique_collector
//  Purpose  : Scoreboard bench for clique_collector (DEPTH 128 and DEPTH 8).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clique_collector;

    localparam int VW = 10;
    localparam int SW = 5;
    localparam int MAX_CYCLES = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > MAX_CYCLES) begin
            n_fail++;
            $display("FAIL timeout: test sequence did not finish within %0d cycles", MAX_CYCLES);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    clique_collector_if #(.VW(VW), .SW(SW)) if_a ();
    clique_collector_if #(.VW(VW), .SW(SW)) if_b ();

    logic          start_a = 1'b0, start_b = 1'b0;
    logic [SW-1:0] init_a = '0, init_b = '0;
    logic [6:0]    rd_a = '0;
    logic [2:0]    rd_b = '0;

    logic [SW-1:0] a_max, b_max;
    logic [31:0]   a_ncl, b_ncl;
    logic [7:0]    a_nv;
    logic [3:0]    b_nv;
    logic [15:0]   a_drop, b_drop;
    logic          a_ovf, b_ovf, a_lerr, b_lerr, a_busy, b_busy;
    logic [VW-1:0] a_rd, b_rd;

    clique_collector #(.VW(VW), .SW(SW), .DEPTH(128)) u_dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start_a), .i_init_maxsize(init_a),
        .clq(if_a.slave), .o_maxsize(a_max), .o_n_cliques(a_ncl), .o_n_vertices(a_nv),
        .o_dropped(a_drop), .o_overflow(a_ovf), .o_len_err(a_lerr), .o_busy(a_busy),
        .i_rd_addr(rd_a), .o_rd_data(a_rd)
    );

    clique_collector #(.VW(VW), .SW(SW), .DEPTH(8)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b), .i_init_maxsize(init_b),
        .clq(if_b.slave), .o_maxsize(b_max), .o_n_cliques(b_ncl), .o_n_vertices(b_nv),
        .o_dropped(b_drop), .o_overflow(b_ovf), .o_len_err(b_lerr), .o_busy(b_busy),
        .i_rd_addr(rd_b), .o_rd_data(b_rd)
    );

    // Selector codes for the observed output
    localparam int MAX = 0, NCL = 1, NV = 2, DROP = 3, OVF = 4, LERR = 5, BUSY = 6, RD = 7;

    typedef struct {
        int           due;
        int           dut;
        int           sel;
        logic [31:0]  exp;
        logic [127:0] name;
    } chk_t;

    chk_t sb[$];
    int   vq[$];

    function automatic logic [31:0] actual(int d, int sel);
        logic [31:0] r;
        r = '0;
        if (d == 0) begin
            case (sel)
                MAX:  r = 32'(a_max);
                NCL:  r = a_ncl;
                NV:   r = 32'(a_nv);
                DROP: r = 32'(a_drop);
                OVF:  r = 32'(a_ovf);
                LERR: r = 32'(a_lerr);
                BUSY: r = 32'(a_busy);
                default: r = 32'(a_rd);
            endcase
        end else begin
            case (sel)
                MAX:  r = 32'(b_max);
                NCL:  r = b_ncl;
                NV:   r = 32'(b_nv);
                DROP: r = 32'(b_drop);
                OVF:  r = 32'(b_ovf);
                LERR: r = 32'(b_lerr);
                BUSY: r = 32'(b_busy);
                default: r = 32'(b_rd);
            endcase
        end
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        int          idx;
        logic [31:0] act;
        idx = 0;
        while (idx < sb.size()) begin
            if (sb[idx].due <= cyc) begin
                act = actual(sb[idx].dut, sb[idx].sel);
                n_tests++;
                if (act !== sb[idx].exp) begin
                    n_fail++;
                    $display("FAIL %0s (dut %0d): got %0d, expected %0d",
                             sb[idx].name, sb[idx].dut, act, sb[idx].exp);
                end
                sb.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    task automatic push(int due, int d, int sel, logic [31:0] e, logic [127:0] nm);
        chk_t c;
        c.due  = due;
        c.dut  = d;
        c.sel  = sel;
        c.exp  = e;
        c.name = nm;
        sb.push_back(c);
    endtask

    task automatic expect_now(int d, int sel, logic [31:0] e, logic [127:0] nm);
        push(cyc, d, sel, e, nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, bit vld, int sz, int v);
        if (d == 0) begin
            if_a.clq_valid = vld;
            if_a.clq_size  = SW'(sz);
            if_a.clq_v     = VW'(v);
        end else begin
            if_b.clq_valid = vld;
            if_b.clq_size  = SW'(sz);
            if_b.clq_v     = VW'(v);
        end
    endtask

    task automatic do_start(int d, int init);
        step();
        if (d == 0) begin start_a = 1'b1; init_a = SW'(init); end
        else        begin start_b = 1'b1; init_b = SW'(init); end
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Sends the vertices in vq as one burst, then one idle cycle is sampled
    task automatic burst(int d, int sz);
        foreach (vq[k]) begin
            step();
            drive(d, 1'b1, sz, vq[k]);
        end
        step();
        drive(d, 1'b0, 0, 0);
        step();
    endtask

    task automatic read(int d, int addr, logic [31:0] e, logic [127:0] nm);
        step();
        if (d == 0) rd_a = 7'(addr);
        else        rd_b = 3'(addr);
        push(cyc + 1, d, RD, e, nm);
    endtask

    initial begin
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        step(); step(); step();
        expect_now(0, MAX,  0, "rst_maxsize");
        expect_now(0, NCL,  0, "rst_ncliques");
        expect_now(0, NV,   0, "rst_nvert");
        expect_now(0, DROP, 0, "rst_dropped");
        expect_now(0, OVF,  0, "rst_overflow");
        expect_now(0, LERR, 0, "rst_len_err");
        expect_now(0, BUSY, 0, "rst_busy");
        expect_now(0, RD,   0, "rst_rd_data");
        n_tests++;
        if ((b_max !== '0) || (b_ncl !== '0) || (b_nv !== '0) || (b_drop !== '0) ||
            (b_ovf !== 1'b0) || (b_lerr !== 1'b0) || (b_busy !== 1'b0) || (b_rd !== '0)) begin
            n_fail++;
            $display("FAIL rst_state_b: max=%0d ncl=%0d nv=%0d drop=%0d ovf=%0d lerr=%0d busy=%0d rd=%0d",
                     b_max, b_ncl, b_nv, b_drop, b_ovf, b_lerr, b_busy, b_rd);
        end
        step();
        rst_n = 1'b1;

        // New maximum from the initial threshold
        do_start(0, 3);
        vq = '{1, 5, 7, 9};
        burst(0, 4);
        expect_now(0, MAX,  4, "t1_maxsize");
        expect_now(0, NCL,  1, "t1_ncliques");
        expect_now(0, NV,   4, "t1_nvert");
        expect_now(0, BUSY, 0, "t1_busy");
        read(0, 0, 1, "t1_rd0");
        read(0, 1, 5, "t1_rd1");
        read(0, 2, 7, "t1_rd2");
        read(0, 3, 9, "t1_rd3");
        step();

        // Second clique of equal size appends
        vq = '{2, 3, 4, 6};
        burst(0, 4);
        expect_now(0, NCL, 2, "t2_ncliques");
        expect_now(0, NV,  8, "t2_nvert");
        read(0, 4, 2, "t2_rd4");
        read(0, 7, 6, "t2_rd7");
        step();

        // Larger clique restarts storage
        vq = '{0, 1, 2, 3, 8};
        burst(0, 5);
        expect_now(0, MAX, 5, "t3_maxsize");
        expect_now(0, NCL, 1, "t3_ncliques");
        expect_now(0, NV,  5, "t3_nvert");
        read(0, 0, 0, "t3_rd0");
        read(0, 4, 8, "t3_rd4");
        step();

        // Smaller clique dropped, then a short burst flags a length error
        vq = '{7, 7, 7};
        burst(0, 3);
        expect_now(0, DROP, 1, "t4_dropped");
        expect_now(0, MAX,  5, "t4_maxsize");
        expect_now(0, NCL,  1, "t4_ncliques");
        expect_now(0, NV,   5, "t4_nvert");
        expect_now(0, LERR, 0, "t4_len_err_pre");
        vq = '{9, 8, 7, 6};
        burst(0, 5);
        expect_now(0, LERR, 1, "t4_len_err");
        expect_now(0, NCL,  2, "t4_ncliques2");
        expect_now(0, NV,   9, "t4_nvert2");
        read(0, 5, 9, "t4_rd5");
        read(0, 8, 6, "t4_rd8");
        step();

        // Small storage overflows on the ninth vertex
        do_start(1, 0);
        vq = '{1, 2, 3};
        burst(1, 3);
        vq = '{4, 5, 6};
        burst(1, 3);
        vq = '{7, 8, 15};
        burst(1, 3);
        expect_now(1, NCL,  3, "t5_ncliques");
        expect_now(1, NV,   8, "t5_nvert");
        expect_now(1, OVF,  1, "t5_overflow");
        expect_now(1, MAX,  3, "t5_maxsize");
        expect_now(1, LERR, 0, "t5_len_err");
        read(1, 0, 1, "t5_rd0_unwrapped");
        read(1, 7, 8, "t5_rd7");
        step();

        // Start on the second beat of a burst
        step(); drive(0, 1'b1, 4, 1);
        step(); drive(0, 1'b1, 4, 2); start_a = 1'b1; init_a = 5'd2;
        step(); drive(0, 1'b1, 4, 3); start_a = 1'b0;
        expect_now(0, BUSY, 1, "t6_busy_a");
        expect_now(0, NCL,  0, "t6_ncliques_a");
        expect_now(0, MAX,  2, "t6_maxsize");
        step(); drive(0, 1'b1, 4, 4);
        expect_now(0, BUSY, 1, "t6_busy_b");
        step(); drive(0, 1'b0, 0, 0);
        expect_now(0, BUSY, 1, "t6_busy_c");
        step();
        expect_now(0, BUSY, 0, "t6_busy_low");
        expect_now(0, NCL,  0, "t6_ncliques");
        expect_now(0, NV,   0, "t6_nvert");
        expect_now(0, DROP, 0, "t6_dropped");
        expect_now(0, OVF,  0, "t6_overflow");
        expect_now(0, LERR, 0, "t6_len_err");

        // Asynchronous reset in the middle of a burst
        step(); drive(0, 1'b1, 3, 11);
        step(); drive(0, 1'b1, 3, 12);
        step(); drive(0, 1'b1, 3, 13);
        #2;
        rst_n = 1'b0;
        expect_now(0, MAX,  0, "t7_rst_maxsize");
        expect_now(0, NCL,  0, "t7_rst_ncliques");
        expect_now(0, NV,   0, "t7_rst_nvert");
        expect_now(0, BUSY, 0, "t7_rst_busy");
        expect_now(0, RD,   0, "t7_rst_rd_data");
        step(); rst_n = 1'b1; drive(0, 1'b1, 3, 14);
        step(); drive(0, 1'b0, 0, 0);
        step();
        expect_now(0, MAX,  3, "t7_maxsize");
        expect_now(0, NCL,  1, "t7_ncliques");
        expect_now(0, NV,   1, "t7_nvert");
        expect_now(0, LERR, 1, "t7_len_err");

        step(); step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
